bfp16_accum: RTL and testbench

- Downstream consumer of the bfp16_mult product stream.
- Accepts bfloat16 products (1 sign, 8 exponent bits with bias 127, 7 mantissa bits) on a valid/ready input.
- Sums up to ACC_LEN products per group and presents each group sum on a valid/ready output.
- Together with the multiplier, it forms the MAC reduction for one dot-product lane of the matmul array.

---
 rtl/bfp16_accum_if.sv | 24 ++
 rtl/bfp16_accum.sv | 127 ++++++++++++
 tb/tb_bfp16_accum.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bfp16_accum_if.sv
// rtl/bfp16_accum_if.sv - product input and group-sum output handshake bundle for bfp16_accum
interface bfp16_accum_if #(
  parameter int DATA_TYPE = 16,
  parameter int CNT_W     = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_TYPE-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_TYPE-1:0] out_data;
  logic [CNT_W-1:0]     out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/bfp16_accum.sv
// rtl/bfp16_accum.sv - bfloat16 group accumulator: sums up to ACC_LEN products per output group
module bfp16_accum #(
  parameter int DATA_TYPE = 16,
  parameter int ACC_LEN   = 4,
  parameter int CNT_W     = $clog2(ACC_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  bfp16_accum_if.slave   bus
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]           state_q;
  logic [DATA_TYPE-1:0] acc_q;
  logic [CNT_W-1:0]     count_q;
  logic [DATA_TYPE-1:0] out_data_q;
  logic [CNT_W-1:0]     out_count_q;

  logic [DATA_TYPE-1:0] sum_d;
  logic [CNT_W-1:0]     count_d;
  logic                 accept;
  logic                 close;

  // Truncating bfloat16 add; NaN results carry exponent 0xFF so they stay sticky via acc_q.
  function automatic logic [15:0] bf16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]        big;
    logic [15:0]        sml;
    logic [7:0]         diff;
    logic [7:0]         m_big;
    logic [7:0]         m_sml;
    logic [8:0]         sum;
    logic [7:0]         norm;
    logic [3:0]         lz;
    logic signed [9:0]  exp_r;
    logic [15:0]        res;
    big   = a;
    sml   = b;
    diff  = 8'd0;
    m_big = 8'd0;
    m_sml = 8'd0;
    sum   = 9'd0;
    norm  = 8'd0;
    lz    = 4'd0;
    exp_r = 10'sd0;
    res   = 16'h0000;
    if (a[14:7] == 8'hFF || b[14:7] == 8'hFF) begin
      res = 16'h7FC0;
    end else if (a[14:7] == 8'h00 && b[14:7] == 8'h00) begin
      res = 16'h0000;
    end else if (a[14:7] == 8'h00) begin
      res = b;
    end else if (b[14:7] == 8'h00) begin
      res = a;
    end else begin
      if (a[14:0] < b[14:0]) begin
        big = b;
        sml = a;
      end
      diff  = big[14:7] - sml[14:7];
      m_big = {1'b1, big[6:0]};
      m_sml = (diff >= 8'd9) ? 8'd0 : ({1'b1, sml[6:0]} >> diff);
      if (big[15] == sml[15]) begin
        sum = {1'b0, m_big} + {1'b0, m_sml};
      end else begin
        sum = {1'b0, m_big} - {1'b0, m_sml};
      end
      if (sum[8]) begin
        norm  = sum[8:1];
        exp_r = $signed({2'b00, big[14:7]}) + 10'sd1;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (sum[i]) lz = 4'(7 - i);
        end
        norm  = sum[7:0] << lz;
        exp_r = $signed({2'b00, big[14:7]}) - $signed({6'b000000, lz});
      end
      if (sum == 9'd0 || exp_r <= 10'sd0) begin
        res = 16'h0000;
      end else if (exp_r >= 10'sd255) begin
        res = big[15] ? 16'hFF7F : 16'h7F7F;
      end else begin
        res = {big[15], exp_r[7:0], norm[6:0]};
      end
    end
    return res;
  endfunction

  assign bus.in_ready  = rst && (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

  always_comb begin
    sum_d   = bf16_add(acc_q, bus.in_data);
    count_d = count_q + 1'b1;
    accept  = bus.in_valid && bus.in_ready;
    close   = accept && (bus.in_last || count_d == CNT_W'(ACC_LEN));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else if (state_q == ST_ACCUM) begin
      if (accept) begin
        acc_q   <= sum_d;
        count_q <= count_d;
      end
      if (close) begin
        state_q     <= ST_HOLD;
        out_data_q  <= sum_d;
        out_count_q <= count_d;
      end
    end else if (bus.out_ready) begin
      // The slot freed by the handshake is not reused for input, so each group costs one extra cycle.
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      count_q <= '0;
    end
  end

endmodule

// File: tb/tb_bfp16_accum.sv
// tb/tb_bfp16_accum.sv - randomized, model-checked bench for bfp16_accum
module tb_bfp16_accum;
  localparam int ACC_LEN = 4;
  localparam int CNT_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bfp16_accum_if #(.DATA_TYPE(16), .CNT_W(CNT_W)) bus ();

  bfp16_accum #(.DATA_TYPE(16), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int rdy_mode = 0;
  logic [15:0] last_data = 16'h0;
  int          last_cnt  = 0;

  logic [15:0] macc = 16'h0;
  int          mcnt = 0;
  bit          exp_next = 1'b0;
  logic [15:0] q_data[$];
  int          q_cnt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference add: value = m * 2^(e-134); smaller operand aligned by integer division, then renormalised.
  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, d, sml, r, e, t;
    bit sa, sb;
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    if (ea == 255 || eb == 255) return 16'h7FC0;
    if (ea == 0 && eb == 0) return 16'h0000;
    if (ea == 0) return b;
    if (eb == 0) return a;
    ma = 128 + int'(a[6:0]); mb = 128 + int'(b[6:0]);
    sa = a[15]; sb = b[15];
    if (ea * 256 + ma < eb * 256 + mb) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      t = int'(sa); sa = sb; sb = t[0];
    end
    d   = ea - eb;
    sml = (d >= 9) ? 0 : mb / (1 << d);
    r   = (sa == sb) ? ma + sml : ma - sml;
    if (r == 0) return 16'h0000;
    e = ea;
    while (r >= 256) begin r = r / 2; e++; end
    while (r < 128) begin r = r * 2; e--; end
    if (e >= 255) return sa ? 16'hFF7F : 16'h7F7F;
    if (e <= 0) return 16'h0000;
    return {sa, e[7:0], r[6:0]};
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (exp_next) begin
        chk("latency_out_valid", bus.out_valid, 1);
        exp_next = 1'b0;
      end
      chk("in_ready_vs_out_valid", bus.in_ready, !bus.out_valid);
      if (bus.out_valid) begin
        if (q_data.size() == 0) begin
          chk("unexpected_out_valid", bus.out_valid, 0);
        end else begin
          chk("out_data", bus.out_data, q_data[0]);
          chk("out_count", bus.out_count, q_cnt[0]);
          if (bus.out_ready) begin
            last_data = bus.out_data;
            last_cnt  = int'(bus.out_count);
            void'(q_data.pop_front());
            void'(q_cnt.pop_front());
            hs_cnt++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        macc = m_add(macc, bus.in_data);
        mcnt++;
        if (bus.in_last || mcnt == ACC_LEN) begin
          q_data.push_back(macc);
          q_cnt.push_back(mcnt);
          macc = 16'h0; mcnt = 0; exp_next = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 60) begin
        chk("send_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_hs(input int start);
    int n;
    n = 0;
    while (hs_cnt <= start && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt <= start) chk("handshake_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic group(input logic [15:0] d[$], input bit use_last, input logic [15:0] req, input int req_cnt, input string name);
    int s;
    s = hs_cnt;
    foreach (d[i]) send(d[i], use_last && (i == d.size() - 1));
    wait_hs(s);
    chk({name, "_data"}, last_data, req);
    chk({name, "_count"}, last_cnt, req_cnt);
  endtask

  function automatic logic [15:0] rand_bf16();
    int r, e;
    r = $urandom_range(0, 99);
    if (r < 3) e = 255;
    else if (r < 8) e = 0;
    else if (r < 13) e = $urandom_range(250, 254);
    else e = $urandom_range(110, 140);
    return {1'($urandom_range(0, 1)), 8'(e), 7'($urandom_range(0, 127))};
  endfunction

  initial begin
    logic [15:0] held_d;
    int s, n;
    bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_count", bus.out_count, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    group('{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 0, 16'h4080, 4, "t1_four_ones");
    group('{16'h4000, 16'h4040}, 1, 16'h40A0, 2, "t2_last");
    group('{16'h3F80}, 1, 16'h3F80, 1, "t2_fresh_group");
    group('{16'h3F80, 16'hBF80, 16'h0000, 16'h0040}, 0, 16'h0000, 4, "t3_cancel");
    group('{16'h3F80, 16'h3B80}, 1, 16'h3F80, 2, "t3_trunc");
    group('{16'h7F7F, 16'h7F7F}, 1, 16'h7F7F, 2, "t4_sat");
    group('{16'h3F80, 16'h7F80, 16'h3F80}, 1, 16'h7FC0, 3, "t4_nan");
    group('{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 1, 16'h4080, 4, "last_on_final");

    rdy_mode = 1;
    @(posedge clk); #1;
    s = hs_cnt;
    send(16'h4000, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 10) begin @(posedge clk); #1; n++; end
    held_d = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", bus.out_data, 16'h4000);
      chk("bp_out_count", bus.out_count, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    rdy_mode = 0;
    wait_hs(s);
    chk("bp_hs_count", hs_cnt, s + 1);
    @(negedge clk);
    chk("bp_in_ready_after", bus.in_ready, 1);
    chk("bp_held_data", held_d, 16'h4000);
    @(posedge clk); #1;

    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b0);
    #2 rst = 1'b0;
    macc = 16'h0; mcnt = 0; exp_next = 1'b0;
    q_data.delete(); q_cnt.delete();
    #1;
    chk("async_rst_in_ready", bus.in_ready, 0);
    chk("async_rst_out_valid", bus.out_valid, 0);
    chk("async_rst_out_data", bus.out_data, 0);
    chk("async_rst_out_count", bus.out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    group('{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 0, 16'h4080, 4, "t6_after_rst");

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      send(rand_bf16(), $urandom_range(0, 9) == 0);
    end
    rdy_mode = 0;
    n = 0;
    while (q_data.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("drain_queue_empty", q_data.size(), 0);
    chk("model_residual_count", mcnt >= 0 && mcnt < ACC_LEN, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
